pc_fetch: RTL
=============

// Module: pc_fetch
// PURPOSE
//  Instruction-fetch / next-PC stage feeding the control decoder (op, func) and consuming its
//  prsource select. Holds PC and instruction register (IR). Fetches from instruction memory via
//  a req/valid handshake, presents the instruction for execution, then updates PC on retire.
//  Two-state sequencer; minimum 2 cycles per instruction; tolerates multi-cycle memory.
// PARAMETERS
//  PC_RESET   32'h0000_0000   PC value loaded on reset
//  IR_RESET   32'h0000_0000   IR value on reset (sll $0,$0,0 = nop)
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch address (= pc)
//  imem_rdata   in   32  instruction word from memory
//  imem_valid   in   1   imem_rdata valid this cycle
//  prsource     in   2   next-PC select from control: 00 seq, 01 branch, 10 jr, 11 j/jal
//  rs_data      in   32  register rs value (jr target)
//  retire       in   1   current instruction completes this cycle; apply prsource
//  instr        out  32  IR contents
//  op           out  6   IR[31:26]
//  func         out  6   IR[5:0]
//  instr_valid  out  1   IR holds an instruction awaiting retire
//  pc           out  32  PC of the instruction in IR
//  pc_plus4     out  32  pc + 4 (jal link value)
//  retire_cnt   out  32  count of retired instructions
// BEHAVIOUR
//  Reset (rst=1 at posedge, any state): pc<=PC_RESET, IR<=IR_RESET, state<=FETCH, retire_cnt<=0.
//   Outputs after reset: instr_valid=0, imem_req=1, imem_addr=PC_RESET. Reset overrides all.
//  FETCH: imem_req=1, instr_valid=0. On posedge with imem_valid=1: IR<=imem_rdata, ->EXEC.
//   imem_valid=0: stay, pc/IR unchanged, imem_addr held stable. retire ignored in FETCH.
//  EXEC: imem_req=0, instr_valid=1. imem_valid ignored. On posedge with retire=1:
//   pc<=npc, retire_cnt<=retire_cnt+1 (wraps at 2^32), ->FETCH. retire=0: hold indefinitely.
//  npc (combinational, from registered pc and IR):
//   00: pc+4
//   01: pc+4 + {{14{IR[15]}}, IR[15:0], 2'b00}
//   10: {rs_data[31:2], 2'b00} (misaligned low bits forced to zero)
//   11: {pc_plus4[31:28], IR[25:0], 2'b00}
//  Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC -> pc_plus4=0; branch targets wrap silently.
//  prsource/rs_data sampled only at retire edge in EXEC; other cycles don't care.
//  Zero-wait memory (imem_valid same cycle as req): 1 cycle FETCH + >=1 cycle EXEC.
//  op/func/pc/pc_plus4 are combinational from registers; stable for all of EXEC.
// STRUCTURE
//  Shared package mips_pkg: PRSRC_SEQ/BR/JR/J 2-bit constants, state enum {FETCH,EXEC},
//   opcode/func constants already used by the control decoder, PC_RESET default.
//  Sub-module npc_calc (combinational): pc, IR, rs_data, prsource -> npc, pc_plus4.
//  Top: state register, pc/IR/retire_cnt registers, handshake outputs.
// TESTING
//  1 rst=1 then release, imem_valid=1 with 32'h2008_0005 -> imem_addr=0, next cycle
//    instr_valid=1, op=6'h08; retire -> pc=4, retire_cnt=1.
//  2 pc=0x100, IR=beq offset 16'hFFFE, prsource=01, retire -> pc=0xFC; offset 0x0003 -> 0x110.
//  3 pc=0x0040_0010, IR=jal 26'h010_0000, prsource=11 -> pc=0x0040_0000; pc_plus4=0x0040_0014 before.
//  4 prsource=10, rs_data=32'h0000_1237 -> pc=0x0000_1234; pc=32'hFFFF_FFFC, 00 -> pc=0.
//  5 imem_valid low 3 cycles in FETCH, retire pulsed meanwhile -> no pc/IR/count change,
//    imem_addr stable; EXEC with retire low 5 cycles -> instr_valid held, pc unchanged.
//  6 rst asserted in EXEC and in FETCH mid-wait -> next cycle pc=PC_RESET, instr_valid=0,
//    IR=0, retire_cnt=0, imem_req=1.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared next-PC selects, sequencer states and opcode constants for the fetch stage.
package pc_fetch_pkg;
  localparam logic [1:0] PRSRC_SEQ = 2'b00;
  localparam logic [1:0] PRSRC_BR = 2'b01;
  localparam logic [1:0] PRSRC_JR = 2'b10;
  localparam logic [1:0] PRSRC_J = 2'b11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] IR_RESET_DEF = 32'h0000_0000;
  typedef enum logic {FETCH, EXEC} state_e;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/valid handshake between fetch stage and memory.
interface pc_fetch_if;
  logic req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic valid;
  modport master (output req, addr, input rdata, valid);
  modport slave (input req, addr, output rdata, valid);
endinterface

// File: rtl/pc_fetch_npc_calc.sv
// pc_fetch_npc_calc: combinational next-PC selection for sequential, branch, jr and j/jal.
module pc_fetch_npc_calc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] imm_i,
  input  logic [29:0] rs_word_i,
  input  logic [1:0]  prsource_i,
  output logic [31:0] npc_o,
  output logic [31:0] pc_plus4_o
);
  logic [31:0] br_off;
  assign pc_plus4_o = pc_i + 32'd4;
  assign br_off = {{14{imm_i[15]}}, imm_i[15:0], 2'b00};
  assign npc_o = prsource_i == PRSRC_SEQ ? pc_plus4_o :
                 prsource_i == PRSRC_BR  ? pc_plus4_o + br_off :
                 prsource_i == PRSRC_JR  ? {rs_word_i, 2'b00} :
                                           {pc_plus4_o[31:28], imm_i, 2'b00};
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: two-state fetch/exec sequencer holding PC, IR and the retired-instruction count.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IR_RESET = IR_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_if.master        imem,
  input  logic [1:0]        prsource,
  input  logic [31:0]       rs_data,
  input  logic              retire,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       retire_cnt
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, cnt_q, cnt_d, npc;
  logic unused_rs_low;
  assign unused_rs_low = ^rs_data[1:0];
  pc_fetch_npc_calc u_npc (
    .pc_i       (pc_q),
    .imm_i      (ir_q[25:0]),
    .rs_word_i  (rs_data[31:2]),
    .prsource_i (prsource),
    .npc_o      (npc),
    .pc_plus4_o (pc_plus4)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= PC_RESET;
      ir_q <= IR_RESET;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    cnt_d = cnt_q;
    if (state_q == FETCH) begin
      if (imem.valid) begin
        ir_d = imem.rdata;
        state_d = EXEC;
      end
    end else if (retire) begin
      pc_d = npc;
      cnt_d = cnt_q + 32'd1;
      state_d = FETCH;
    end
  end
  assign imem.req = state_q == FETCH;
  assign imem.addr = pc_q;
  assign instr_valid = state_q == EXEC;
  assign instr = ir_q;
  assign op = ir_q[31:26];
  assign func = ir_q[5:0];
  assign pc = pc_q;
  assign retire_cnt = cnt_q;
endmodule
